// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register feeding a 2-entry {instr, pc+4} FIFO toward IF/ID.
// Redirect flushes the FIFO and restarts fetch at the new word-aligned address.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr_out,
    output logic [31:0] pc_incr_out,
    output logic        valid_out
);

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] fifo_instr [2];
    logic [31:0] fifo_pc4   [2];
    logic [1:0]  count;
    logic        fire;
    logic        pop;

    assign pc_next   = pc + 32'd4;
    assign imem_addr = pc;
    assign imem_req  = (count < 2'd2) && !redirect && !reset;
    assign fire      = imem_req && imem_ready;
    assign valid_out = (count != 2'd0);
    assign pop       = valid_out && !stall && !redirect;

    assign Instr_out   = valid_out ? fifo_instr[0] : 32'd0;
    assign pc_incr_out = valid_out ? fifo_pc4[0]   : 32'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc            <= RESET_PC;
            count         <= 2'd0;
            fifo_instr[0] <= 32'd0;
            fifo_instr[1] <= 32'd0;
            fifo_pc4[0]   <= 32'd0;
            fifo_pc4[1]   <= 32'd0;
        end else if (redirect) begin
            pc    <= {redirect_pc[31:2], 2'b00};
            count <= 2'd0;
        end else begin
            if (fire) begin
                pc <= pc_next;
            end
            unique case ({fire, pop})
                2'b10: begin
                    fifo_instr[count[0]] <= imem_rdata;
                    fifo_pc4[count[0]]   <= pc_next;
                    count                <= count + 2'd1;
                end
                2'b01: begin
                    fifo_instr[0] <= fifo_instr[1];
                    fifo_pc4[0]   <= fifo_pc4[1];
                    count         <= count - 2'd1;
                end
                2'b11: begin
                    // Fetch only happens below full, so the head leaves and the new word
                    // lands in slot 0 when count==1, or behind the survivor otherwise.
                    if (count == 2'd1) begin
                        fifo_instr[0] <= imem_rdata;
                        fifo_pc4[0]   <= pc_next;
                    end else begin
                        fifo_instr[0] <= fifo_instr[1];
                        fifo_pc4[0]   <= fifo_pc4[1];
                        fifo_instr[1] <= imem_rdata;
                        fifo_pc4[1]   <= pc_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a queue-based scoreboard of fetched {instr, pc+4}
// entries, driven alongside an independent PC model and an address-hashed memory.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] Instr_out;
    logic [31:0] pc_incr_out;
    logic        valid_out;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] sb[$];
    logic [31:0] m_pc;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .Instr_out   (Instr_out),
        .pc_incr_out (pc_incr_out),
        .valid_out   (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs at negedge, check outputs against the model,
    // then advance the model to what the coming posedge should produce.
    task automatic step(input logic rdy, input logic stl, input logic rdr, input logic [31:0] rpc);
        logic [63:0] head;
        logic        exp_req;
        logic        fire;
        logic        pop;
        @(negedge clk);
        reset       = 1'b0;
        imem_ready  = rdy;
        stall       = stl;
        redirect    = rdr;
        redirect_pc = rpc;
        #1;
        exp_req = (sb.size() < 2) && !rdr;
        head    = (sb.size() != 0) ? sb[0] : 64'd0;
        chk("imem_req",    {31'd0, imem_req},  {31'd0, exp_req});
        chk("imem_addr",   imem_addr,          m_pc);
        chk("valid_out",   {31'd0, valid_out}, {31'd0, sb.size() != 0});
        chk("Instr_out",   Instr_out,          head[63:32]);
        chk("pc_incr_out", pc_incr_out,        head[31:0]);
        fire = exp_req && rdy;
        pop  = (sb.size() != 0) && !stl && !rdr;
        if (rdr) begin
            sb.delete();
            m_pc = {rpc[31:2], 2'b00};
        end else begin
            if (pop) void'(sb.pop_front());
            if (fire) begin
                sb.push_back({mem_word(m_pc), m_pc + 32'd4});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        imem_ready  = 1'b0;
        m_pc        = RESET_PC;

        #3;
        chk("rst_valid", {31'd0, valid_out}, 32'd0);
        chk("rst_instr", Instr_out, 32'd0);
        chk("rst_pc4",   pc_incr_out, 32'd0);
        chk("rst_req",   {31'd0, imem_req}, 32'd0);
        chk("rst_addr",  imem_addr, RESET_PC);

        // Back-to-back stream A,B,C then a few more.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 32'd0);
        // Stall with memory ready: FIFO fills and requests stop.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 32'd0);
        // Fill, then redirect with an unaligned target while full.
        step(1'b1, 1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0103);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'd0);
        // Memory ready gaps 1,0,0,1 after draining.
        step(1'b0, 1'b0, 1'b1, 32'h0000_0200);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        // PC wrap at the top of the address space.
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 32'd0);
        // Randomised traffic.
        for (int i = 0; i < 200; i++)
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 11) == 0), $urandom);

        // Asynchronous reset between edges with one entry held.
        step(1'b1, 1'b0, 1'b1, 32'h0000_0440);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        @(negedge clk);
        #2;
        chk("pre_valid", {31'd0, valid_out}, 32'd1);
        reset = 1'b1;
        #1;
        chk("arst_valid", {31'd0, valid_out}, 32'd0);
        chk("arst_instr", Instr_out, 32'd0);
        chk("arst_req",   {31'd0, imem_req}, 32'd0);
        chk("arst_addr",  imem_addr, RESET_PC);
        sb.delete();
        m_pc = RESET_PC;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
